// File: rtl/decoder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared definitions for the registered binary decoder:
//   - mode encodings
//   - buffer occupancy state type
//   - decode_word(): combinational code -> word decode with error detection
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam logic [1:0] MODE_ONEHOT   = 2'b00;
    localparam logic [1:0] MODE_THERM    = 2'b01;
    localparam logic [1:0] MODE_ONEHOT_N = 2'b10;
    localparam logic [1:0] MODE_RSVD     = 2'b11;

    // Widest output word decode_word() can build. Callers take the low
    // OUT_W bits of the result.
    localparam int MAX_OUT_W = 64;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic                 err;
        logic [MAX_OUT_W-1:0] word;
    } dec_res_t;

    // Decode one code for an output word of out_w bits. Out-of-range codes
    // and the reserved mode flag err and produce the inactive word: all-1
    // for active-low one-hot, all-0 otherwise. Bits at and above out_w are 0.
    function automatic dec_res_t decode_word(input logic [31:0] code,
                                             input logic [1:0]  mode,
                                             input int          out_w);
        dec_res_t res;
        res.err  = (code >= 32'(out_w)) || (mode == MODE_RSVD);
        res.word = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            if (i < out_w) begin
                if (res.err) begin
                    res.word[i] = (mode == MODE_ONEHOT_N);
                end else begin
                    case (mode)
                        MODE_ONEHOT:   res.word[i] = (32'(i) == code);
                        MODE_THERM:    res.word[i] = (32'(i) <= code);
                        MODE_ONEHOT_N: res.word[i] = (32'(i) != code);
                        default:       res.word[i] = 1'b0;
                    endcase
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_pipe_if.sv
// -----------------------------------------------------------------------------
// decoder_pipe_if
//   Handshake bundle for decoder_pipe.
//   Input side : in_valid, in_ready, in_code[IN_W], mode[2]
//   Output side: out_valid, out_ready, y[OUT_W]
//   Error      : err_clr, err_code
//   master = producer/consumer driving the block, slave = decoder_pipe.
// -----------------------------------------------------------------------------
interface decoder_pipe_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;
    logic             err_clr;
    logic             err_code;

    modport master (
        output in_valid, in_code, mode, out_ready, err_clr,
        input  in_ready, out_valid, y, err_code
    );

    modport slave (
        input  in_valid, in_code, mode, out_ready, err_clr,
        output in_ready, out_valid, y, err_code
    );
endinterface

// File: rtl/decoder_pipe_fifo2.sv
// -----------------------------------------------------------------------------
// dec_fifo2
//   Two-entry first-word-fall-through buffer. dout always shows the head
//   entry; it resets to 0.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-low
//   push  : write din (ignored when full)
//   din   : write data [W]
//   pop   : drop head entry (ignored when empty)
//   dout  : head entry [W]
//   full  : two entries held
//   empty : no entries held
// -----------------------------------------------------------------------------
module dec_fifo2
    import decoder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    occ_t         occ_reg,  occ_next;
    logic [W-1:0] head_reg, head_next;
    logic [W-1:0] tail_reg, tail_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_reg  <= OCC_EMPTY;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            occ_reg  <= occ_next;
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        tail_next = tail_reg;
        case (occ_reg)
            OCC_EMPTY: begin
                if (push) begin
                    head_next = din;
                    occ_next  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    // Head leaves and the new word replaces it directly.
                    head_next = din;
                end else if (push) begin
                    tail_next = din;
                    occ_next  = OCC_TWO;
                end else if (pop) begin
                    occ_next  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    head_next = tail_reg;
                    occ_next  = OCC_ONE;
                end
            end
            default: begin
                occ_next = OCC_EMPTY;
            end
        endcase
    end

    assign dout  = head_reg;
    assign full  = (occ_reg == OCC_TWO);
    assign empty = (occ_reg == OCC_EMPTY);

endmodule

// File: rtl/decoder_pipe.sv
// -----------------------------------------------------------------------------
// decoder_pipe
//   Registered binary decoder: IN_W-bit code -> OUT_W-bit word, with
//   runtime mode (one-hot / thermometer / active-low one-hot), valid/ready
//   on both sides through a 2-entry buffer, and a sticky error flag.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : decoder_pipe_if.slave (in_valid/in_ready/in_code/mode,
//         out_valid/out_ready/y, err_clr/err_code)
//   Parameters: IN_W >= 1, 2 <= OUT_W <= min(2**IN_W, MAX_OUT_W).
// -----------------------------------------------------------------------------
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    decoder_pipe_if.slave  bus
);

    dec_res_t         dec_res;
    logic [OUT_W-1:0] dec_word;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             err_reg, err_next;

    // Decode straight off the input; only the finished word is stored, so
    // mode is captured per push along with the code.
    assign dec_res  = decode_word(32'(bus.in_code), bus.mode, OUT_W);
    assign dec_word = dec_res.word[OUT_W-1:0];

    generate
        if (OUT_W < MAX_OUT_W) begin : g_unused_hi
            logic unused_word_hi;
            assign unused_word_hi = ^dec_res.word[MAX_OUT_W-1:OUT_W];
        end
    endgenerate

    // in_ready depends only on the buffer state register, never on in_valid.
    assign push = bus.in_valid & ~full;
    assign pop  = ~empty & bus.out_ready;

    dec_fifo2 #(
        .W (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (dec_word),
        .pop   (pop),
        .dout  (bus.y),
        .full  (full),
        .empty (empty)
    );

    // Set has priority over clear when both land on the same edge.
    always_comb begin
        err_next = err_reg;
        if (bus.err_clr) begin
            err_next = 1'b0;
        end
        if (push && dec_res.err) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.err_code  = err_reg;

endmodule

// File: tb/tb_decoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_decoder_pipe
//   Directed bench for decoder_pipe: a vector table for the main decode
//   function on an IN_W=3/OUT_W=8 instance, hand sequences for backpressure,
//   X safety and mid-stream reset, and an IN_W=3/OUT_W=6 instance for the
//   out-of-range and error-clear cases.
// -----------------------------------------------------------------------------
module tb_decoder_pipe;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    decoder_pipe_if #(.IN_W(3), .OUT_W(8)) bus_a ();
    decoder_pipe_if #(.IN_W(3), .OUT_W(6)) bus_b ();

    decoder_pipe #(.IN_W(3), .OUT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    decoder_pipe #(.IN_W(3), .OUT_W(6)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [2:0] code;
        logic [1:0] mode;
        logic       ordy;
        logic       clr;
        logic       ev;
        logic [7:0] ey;
        logic       ee;
        logic       er;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [2:0] code, input logic [1:0] mode,
                       input logic ordy, input logic clr, input logic ev,
                       input logic [7:0] ey, input logic ee, input logic er);
        vec_t v;
        v.iv = iv; v.code = code; v.mode = mode; v.ordy = ordy; v.clr = clr;
        v.ev = ev; v.ey = ey; v.ee = ee; v.er = er;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic iv, input logic [2:0] code, input logic [1:0] mode,
                           input logic ordy, input logic clr);
        bus_a.in_valid  = iv;
        bus_a.in_code   = code;
        bus_a.mode      = mode;
        bus_a.out_ready = ordy;
        bus_a.err_clr   = clr;
    endtask

    task automatic drive_b(input logic iv, input logic [2:0] code, input logic [1:0] mode,
                           input logic ordy, input logic clr);
        bus_b.in_valid  = iv;
        bus_b.in_code   = code;
        bus_b.mode      = mode;
        bus_b.out_ready = ordy;
        bus_b.err_clr   = clr;
    endtask

    initial begin
        // Vector table: inputs applied before an edge, outputs checked after it.
        for (int c = 0; c < 8; c++) begin
            add(1'b1, 3'(c), 2'b00, 1'b1, 1'b0, 1'b1, 8'(1 << c), 1'b0, 1'b1);
        end
        add(1'b1, 3'd3, 2'b01, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1);
        add(1'b1, 3'd7, 2'b01, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        add(1'b1, 3'd0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        add(1'b1, 3'd3, 2'b10, 1'b1, 1'b0, 1'b1, 8'hF7, 1'b0, 1'b1);
        add(1'b1, 3'd5, 2'b10, 1'b1, 1'b0, 1'b1, 8'hDF, 1'b0, 1'b1);
        add(1'b1, 3'd3, 2'b11, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        add(1'b0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        rst = 1'b0;
        drive_a(1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
        drive_b(1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
        repeat (2) step();

        chk("reset_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("reset_y",         64'(bus_a.y),         64'd0);
        chk("reset_err",       64'(bus_a.err_code),  64'd0);
        chk("reset_in_ready",  64'(bus_a.in_ready),  64'd1);
        rst = 1'b1;

        foreach (vq[n]) begin
            drive_a(vq[n].iv, vq[n].code, vq[n].mode, vq[n].ordy, vq[n].clr);
            step();
            $display("vec %0d: code=%0d mode=%0d -> valid=%0b y=%02h err=%0b rdy=%0b",
                     n, vq[n].code, vq[n].mode, bus_a.out_valid, bus_a.y,
                     bus_a.err_code, bus_a.in_ready);
            chk($sformatf("vec%0d_valid", n), 64'(bus_a.out_valid), 64'(vq[n].ev));
            if (vq[n].ev)
                chk($sformatf("vec%0d_y", n), 64'(bus_a.y), 64'(vq[n].ey));
            chk($sformatf("vec%0d_err", n),   64'(bus_a.err_code), 64'(vq[n].ee));
            chk($sformatf("vec%0d_ready", n), 64'(bus_a.in_ready), 64'(vq[n].er));
        end

        // Backpressure: codes 1,2,5 with consumer stalled.
        drive_a(1'b1, 3'd1, 2'b00, 1'b0, 1'b0);
        step();
        $display("bp push1: y=%02h rdy=%0b", bus_a.y, bus_a.in_ready);
        chk("bp1_y", 64'(bus_a.y), 64'h02);
        chk("bp1_ready", 64'(bus_a.in_ready), 64'd1);
        drive_a(1'b1, 3'd2, 2'b00, 1'b0, 1'b0);
        step();
        $display("bp push2: y=%02h rdy=%0b", bus_a.y, bus_a.in_ready);
        chk("bp2_y", 64'(bus_a.y), 64'h02);
        chk("bp2_ready", 64'(bus_a.in_ready), 64'd0);
        drive_a(1'b1, 3'd5, 2'b00, 1'b0, 1'b0);
        step();
        $display("bp stall: y=%02h rdy=%0b", bus_a.y, bus_a.in_ready);
        chk("bp3_stall_ready", 64'(bus_a.in_ready), 64'd0);
        chk("bp3_y_held", 64'(bus_a.y), 64'h02);
        drive_a(1'b1, 3'd5, 2'b00, 1'b1, 1'b0);
        step();
        $display("bp drain1: y=%02h rdy=%0b", bus_a.y, bus_a.in_ready);
        chk("bp4_y", 64'(bus_a.y), 64'h04);
        chk("bp4_ready", 64'(bus_a.in_ready), 64'd1);
        step();
        $display("bp drain2: y=%02h", bus_a.y);
        chk("bp5_y", 64'(bus_a.y), 64'h20);
        chk("bp5_valid", 64'(bus_a.out_valid), 64'd1);
        drive_a(1'b0, 3'd0, 2'b00, 1'b1, 1'b0);
        step();
        $display("bp empty: valid=%0b", bus_a.out_valid);
        chk("bp6_valid", 64'(bus_a.out_valid), 64'd0);

        // X safety: hold one word, then idle with X code/mode.
        drive_a(1'b1, 3'd6, 2'b00, 1'b0, 1'b0);
        step();
        chk("x0_y", 64'(bus_a.y), 64'h40);
        drive_a(1'b0, 3'bxxx, 2'bxx, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            $display("xidle %0d: valid=%0b y=%02h err=%0b", k, bus_a.out_valid, bus_a.y, bus_a.err_code);
            chk($sformatf("x%0d_y", k),     64'(bus_a.y),         64'h40);
            chk($sformatf("x%0d_valid", k), 64'(bus_a.out_valid), 64'd1);
            chk($sformatf("x%0d_err", k),   64'(bus_a.err_code),  64'd0);
        end

        // Second entry with reserved mode: buffer full, error set.
        drive_a(1'b1, 3'd1, 2'b11, 1'b0, 1'b0);
        step();
        $display("full: y=%02h err=%0b rdy=%0b", bus_a.y, bus_a.err_code, bus_a.in_ready);
        chk("full_err", 64'(bus_a.err_code), 64'd1);
        chk("full_ready", 64'(bus_a.in_ready), 64'd0);
        drive_a(1'b0, 3'd0, 2'b00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b0;
        #1;
        $display("mid reset: valid=%0b y=%02h err=%0b rdy=%0b",
                 bus_a.out_valid, bus_a.y, bus_a.err_code, bus_a.in_ready);
        chk("mrst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("mrst_y",     64'(bus_a.y),         64'd0);
        chk("mrst_err",   64'(bus_a.err_code),  64'd0);
        chk("mrst_ready", 64'(bus_a.in_ready),  64'd1);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_ready", 64'(bus_a.in_ready),  64'd1);
        chk("post_rst_valid", 64'(bus_a.out_valid), 64'd0);

        // OUT_W=6 instance: range errors and err_clr priority.
        drive_b(1'b1, 3'd6, 2'b10, 1'b1, 1'b0);
        step();
        $display("rng code6 m10: y=%02h err=%0b", bus_b.y, bus_b.err_code);
        chk("rng6_y", 64'(bus_b.y), 64'h3F);
        chk("rng6_err", 64'(bus_b.err_code), 64'd1);
        chk("rng6_valid", 64'(bus_b.out_valid), 64'd1);
        drive_b(1'b1, 3'd7, 2'b00, 1'b1, 1'b1);
        step();
        $display("rng code7 clr: y=%02h err=%0b", bus_b.y, bus_b.err_code);
        chk("rng7_y", 64'(bus_b.y), 64'h00);
        chk("rng7_err_set_wins", 64'(bus_b.err_code), 64'd1);
        drive_b(1'b0, 3'd0, 2'b00, 1'b1, 1'b1);
        step();
        $display("rng clr alone: err=%0b valid=%0b", bus_b.err_code, bus_b.out_valid);
        chk("clr_err", 64'(bus_b.err_code), 64'd0);
        chk("clr_valid", 64'(bus_b.out_valid), 64'd0);
        drive_b(1'b1, 3'd5, 2'b01, 1'b1, 1'b0);
        step();
        $display("rng code5 m01: y=%02h err=%0b", bus_b.y, bus_b.err_code);
        chk("b5_y", 64'(bus_b.y), 64'h3F);
        chk("b5_err", 64'(bus_b.err_code), 64'd0);
        drive_b(1'b1, 3'd2, 2'b10, 1'b1, 1'b0);
        step();
        $display("rng code2 m10: y=%02h", bus_b.y);
        chk("b2_y", 64'(bus_b.y), 64'h3B);
        drive_b(1'b0, 3'd0, 2'b00, 1'b1, 1'b0);
        step();
        chk("b_end_valid", 64'(bus_b.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
